// File: rtl/worley_pkg.sv
// Shared widths, default screen limits, reset tables and FSM encoding
// for the Worley feature-point animator.
package worley_pkg;

  localparam int COORD_W   = 10;
  localparam int VEL_W     = 4;
  localparam int H_MAX_DEF = 639;
  localparam int V_MAX_DEF = 479;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_COMMIT
  } state_t;

  // Tables repeat every four points when NUM_POINTS is larger
  function automatic logic [COORD_W-1:0] init_x(input int i);
    case (i % 4)
      0:       return 10'd100;
      1:       return 10'd300;
      2:       return 10'd500;
      default: return 10'd100;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] init_y(input int i);
    case (i % 4)
      0:       return 10'd100;
      1:       return 10'd200;
      2:       return 10'd400;
      default: return 10'd460;
    endcase
  endfunction

  function automatic logic signed [VEL_W-1:0] init_vx(input int i);
    case (i % 4)
      0:       return 4'sd3;
      1:       return -4'sd2;
      2:       return 4'sd1;
      default: return -4'sd1;
    endcase
  endfunction

  function automatic logic signed [VEL_W-1:0] init_vy(input int i);
    case (i % 4)
      0:       return -4'sd2;
      1:       return 4'sd1;
      2:       return -4'sd3;
      default: return 4'sd2;
    endcase
  endfunction

endpackage

// File: rtl/worley_axis_step.sv
// Single-axis position step with mirror reflection at 0 and at max.
module worley_axis_step
  import worley_pkg::*;
(
  input  logic        [COORD_W-1:0] pos,
  input  logic signed [VEL_W-1:0]   v,
  input  logic        [1:0]         shift,
  input  logic        [COORD_W-1:0] max,
  output logic        [COORD_W-1:0] pos_next,
  output logic signed [VEL_W-1:0]   v_next
);

  localparam int SUM_W = 12;

  logic              [1:0]       sh;
  logic signed       [SUM_W-1:0] step;
  logic signed       [SUM_W-1:0] next;
  logic signed       [SUM_W-1:0] max_s;
  logic signed       [SUM_W-1:0] refl;

  always_comb begin
    sh       = (shift == 2'd3) ? 2'd2 : shift;
    step     = $signed({{(SUM_W-VEL_W){v[VEL_W-1]}}, v}) <<< sh;
    next     = $signed({2'b00, pos}) + step;
    max_s    = $signed({2'b00, max});
    refl     = next;
    v_next   = v;
    if (next < 0) begin
      refl   = -next;
      v_next = -v;
    end else if (next > max_s) begin
      refl   = (max_s <<< 1) - next;
      v_next = -v;
    end
    pos_next = refl[COORD_W-1:0];
  end

endmodule

// File: rtl/worley_point_animator.sv
// Bounces NUM_POINTS feature points once per frame; outputs update atomically.
//   state     | meaning
//   IDLE      | waiting for an unpaused frame_tick
//   UPDATE    | stepping working point idx, one per cycle
//   COMMIT    | publishing working positions, counting the frame
module worley_point_animator
  import worley_pkg::*;
#(
  parameter int NUM_POINTS = 4,
  parameter int H_MAX      = H_MAX_DEF,
  parameter int V_MAX      = V_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          pause,
  input  logic [1:0]                    speed,
  output logic [COORD_W*NUM_POINTS-1:0] points_x,
  output logic [COORD_W*NUM_POINTS-1:0] points_y,
  output logic                          busy,
  output logic                          overrun,
  output logic [19:0]                   frame_count
);

  localparam int IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

  logic        [COORD_W-1:0] wx [NUM_POINTS];
  logic        [COORD_W-1:0] wy [NUM_POINTS];
  logic signed [VEL_W-1:0]   vx [NUM_POINTS];
  logic signed [VEL_W-1:0]   vy [NUM_POINTS];

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               last_idx;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic signed [VEL_W-1:0] vx_nxt, vy_nxt;

  assign busy     = (state != ST_IDLE);
  assign last_idx = (idx == IDX_W'(NUM_POINTS - 1));

  worley_axis_step u_step_x (
    .pos      (wx[idx]),
    .v        (vx[idx]),
    .shift    (speed),
    .max      (COORD_W'(H_MAX)),
    .pos_next (x_nxt),
    .v_next   (vx_nxt)
  );

  worley_axis_step u_step_y (
    .pos      (wy[idx]),
    .v        (vy[idx]),
    .shift    (speed),
    .max      (COORD_W'(V_MAX)),
    .pos_next (y_nxt),
    .v_next   (vy_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_tick && !pause) state_nxt = ST_UPDATE;
      ST_UPDATE: if (last_idx) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      overrun     <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        wx[i] <= init_x(i);
        wy[i] <= init_y(i);
        vx[i] <= init_vx(i);
        vy[i] <= init_vy(i);
        points_x[COORD_W*i +: COORD_W] <= init_x(i);
        points_y[COORD_W*i +: COORD_W] <= init_y(i);
      end
    end else begin
      state <= state_nxt;
      // A paused tick is ignored entirely, so it cannot count as dropped
      if (busy && frame_tick && !pause) overrun <= 1'b1;
      if (state == ST_UPDATE) begin
        wx[idx] <= x_nxt;
        wy[idx] <= y_nxt;
        vx[idx] <= vx_nxt;
        vy[idx] <= vy_nxt;
        idx     <= last_idx ? '0 : idx + IDX_W'(1);
      end
      if (state == ST_COMMIT) begin
        for (int i = 0; i < NUM_POINTS; i++) begin
          points_x[COORD_W*i +: COORD_W] <= wx[i];
          points_y[COORD_W*i +: COORD_W] <= wy[i];
        end
        frame_count <= frame_count + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_worley_point_animator.sv
// Directed bench for worley_point_animator with hand-computed expectations.
module tb_worley_point_animator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [39:0] points_x, points_y;
  logic        busy, overrun;
  logic [19:0] frame_count;

  int checks = 0;
  int errors = 0;
  int n;

  worley_point_animator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .speed       (speed),
    .points_x    (points_x),
    .points_y    (points_y),
    .busy        (busy),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic int px(input int i);
    return int'(points_x[10*i +: 10]);
  endfunction

  function automatic int py(input int i);
    return int'(points_y[10*i +: 10]);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge just after the edge that sampled the tick
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    check("busy_timeout", int'(cycles < 20), 1);
  endtask

  task automatic tick_and_wait();
    int c;
    tick();
    wait_idle(c);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_p0x", px(0), 100);
    check("rst_p0y", py(0), 100);
    check("rst_p2y", py(2), 400);
    check("rst_p3y", py(3), 460);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_fc", int'(frame_count), 0);

    // One tick at speed 0
    speed = 2'd0;
    tick();
    check("busy_after_tick", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    check("no_partial_p0x", px(0), 100);
    check("no_partial_p0y", py(0), 100);
    n = 2;
    begin
      int c;
      wait_idle(c);
      n += c;
    end
    check("busy_cycles", n, 5);
    check("t1_p0x", px(0), 103);
    check("t1_p0y", py(0), 98);
    check("t1_p1x", px(1), 298);
    check("t1_p1y", py(1), 201);
    check("t1_p2x", px(2), 501);
    check("t1_p2y", py(2), 397);
    check("t1_p3x", px(3), 99);
    check("t1_p3y", py(3), 462);
    check("t1_fc", int'(frame_count), 1);
    check("t1_overrun", int'(overrun), 0);

    // Paused ticks do nothing
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_busy", int'(busy), 0);
    end
    pause = 1'b0;
    check("pause_p0x", px(0), 103);
    check("pause_p3y", py(3), 462);
    check("pause_fc", int'(frame_count), 1);
    check("pause_overrun", int'(overrun), 0);

    // Second tick two cycles after the first is dropped
    tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    begin
      int c;
      wait_idle(c);
    end
    repeat (8) @(negedge clk);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_fc", int'(frame_count), 2);
    check("ovr_p0x", px(0), 106);
    check("ovr_p0y", py(0), 96);

    // Reset two cycles into UPDATE abandons the update
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_p0x", px(0), 100);
    check("abort_p0y", py(0), 100);
    check("abort_p1x", px(1), 300);
    check("abort_fc", int'(frame_count), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_busy", int'(busy), 0);

    // Upper reflection at speed 2, then speed 3 behaves as 2
    speed = 2'd2;
    tick_and_wait();
    check("s2_t1_p3y", py(3), 468);
    check("s2_t1_p3x", px(3), 96);
    tick_and_wait();
    check("s2_t2_p3y", py(3), 476);
    tick_and_wait();
    check("s2_t3_p3y", py(3), 474);
    check("s2_t3_p3x", px(3), 88);
    speed = 2'd3;
    tick_and_wait();
    check("s3_t4_p3y", py(3), 466);
    check("s3_t4_p3x", px(3), 84);
    check("s3_fc", int'(frame_count), 4);

    // Lower reflection at speed 0, with zero itself in range
    do_reset();
    speed = 2'd0;
    for (int i = 0; i < 50; i++) tick_and_wait();
    check("low_t50_p0y", py(0), 0);
    check("low_t50_p0x", px(0), 250);
    tick_and_wait();
    check("low_t51_p0y", py(0), 2);
    tick_and_wait();
    check("low_t52_p0y", py(0), 4);
    check("low_fc", int'(frame_count), 52);
    check("low_overrun", int'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/worley_point_animator.md
WORLEY_POINT_ANIMATOR -- requirements
Module: worley_point_animator

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 4, number of feature points.
REQ-002 SHALL have parameter H_MAX, default 639, largest legal x coordinate.
REQ-003 SHALL have parameter V_MAX, default 479, largest legal y coordinate.
REQ-004 SHALL have port clk  input  1  pixel clock; the block's only clock.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have port pause  input  1  1 = ignore frame_tick.
REQ-008 SHALL have port speed  input  2  step shift: 0, 1 or 2; value 3 treated as 2.
REQ-009 SHALL have port points_x  output  10*NUM_POINTS  packed x coordinates, point i at bits [10i+9:10i].
REQ-010 SHALL have port points_y  output  10*NUM_POINTS  packed y coordinates, same packing.
REQ-011 SHALL have port busy  output  1  high while an update is in progress.
REQ-012 SHALL have port overrun  output  1  sticky; set when a tick is dropped because busy.
REQ-013 SHALL have port frame_count  output  20  number of committed updates, wraps modulo 2^20.

Function
REQ-014 SHALL hold, per point, a working position (x, y) and signed 4-bit velocity (vx, vy).
REQ-015 SHALL implement FSM states IDLE, UPDATE, COMMIT.
REQ-016 IDLE SHALL go to UPDATE on the edge where frame_tick=1 and pause=0; otherwise it stays in IDLE.
REQ-017 UPDATE SHALL process one point per cycle, index 0..NUM_POINTS-1, then go to COMMIT.
REQ-018 COMMIT SHALL copy all working positions to points_x/points_y in one edge, increment frame_count, and return to IDLE.
REQ-019 Latency: a tick sampled at edge k SHALL update the outputs at edge k+NUM_POINTS+1, i.e. k+5 by default.
REQ-020 busy SHALL be 1 from edge k through edge k+NUM_POINTS+1 exclusive, and 0 in IDLE.
REQ-021 points_x/points_y SHALL change only at COMMIT, so the downstream generator never sees a partial update.
REQ-022 Per axis, with step = v << min(speed,2): next = pos + step, computed signed at 12 bits.
REQ-023 If next < 0, the axis SHALL become pos = -next and v = -v.
REQ-024 If next > MAX (H_MAX or V_MAX), the axis SHALL become pos = 2*MAX - next and v = -v.
REQ-025 Otherwise the axis SHALL become pos = next with v unchanged; next = 0 and next = MAX are in range.
REQ-026 A frame_tick while busy SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-027 speed and pause SHALL be sampled every cycle; a change mid-UPDATE applies to the remaining points.
REQ-028 frame_count SHALL wrap from 2^20-1 to 0 without side effects.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, busy=0, overrun=0, frame_count=0, point index 0.
REQ-030 Reset positions SHALL be (100,100), (300,200), (500,400), (100,460) for points 0..3, in both working and output registers.
REQ-031 Reset velocities SHALL be (+3,-2), (-2,+1), (+1,-3), (-1,+2).
REQ-032 A reset during UPDATE/COMMIT SHALL abandon the update with no commit and no frame_count increment.

Structure
REQ-033 A shared package worley_pkg SHALL hold the coordinate width (10), velocity width (4), H_MAX/V_MAX defaults, the initial position/velocity tables, and the FSM state enum.
REQ-034 A sub-module worley_axis_step (pos, v, shift, max -> pos_next, v_next; combinational) SHALL implement the single-axis step and reflection, instantiated once for x and once for y.

Verification
REQ-035 Reset, speed=0, one tick: busy high for 5 cycles; after commit point0=(103,98), point1=(298,201), frame_count=1.
REQ-036 speed=2, three ticks: point3 y goes 460 -> 468 -> 476 -> 474, and vy becomes -2 (upper reflection).
REQ-037 speed=0, 51 ticks: point0 y reaches 0 at tick 50 and 2 at tick 51, with vy=+2 (lower reflection, zero in range).
REQ-038 Tick asserted 2 cycles after a prior tick: overrun=1, exactly one commit, frame_count +1 only.
REQ-039 pause=1 with 10 ticks: outputs, frame_count and busy are unchanged.
REQ-040 rst_n low 2 cycles into UPDATE: outputs return to the reset table, frame_count=0, and no commit pulse occurs.
